// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares one unified single-ported memory between the instruction-fetch
//   port (IF) and the MEM-stage data port. A granted request is latched into
//   the memory-side registers and held stable until the memory acknowledges
//   it, or until the wait budget runs out. Read data is returned with a
//   one-cycle valid pulse. Under contention the two requesters alternate.
//
// Ports:
//   clk_i, rst_ni         clock (rising edge), synchronous active-low reset
//   if_req_i, if_addr_i   fetch request (held until if_valid_o) and address
//   if_rdata_o            fetched instruction, held between completions
//   if_valid_o            one-cycle pulse: fetch complete
//   d_read_i, d_write_i   MEM-stage memread / memwrite, held until d_valid_o
//   d_addr_i, d_wdata_i   data address and store data
//   d_wstrb_i             store byte enables
//   d_rdata_o             load data, held between completions
//   d_valid_o             one-cycle pulse: data access complete
//   mem_req_o             memory request, fields stable while high
//   mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o   memory command fields
//   mem_ack_i, mem_rdata_i  memory completion and read data
//   stall_if_o            fetch is waiting (combinational)
//   stall_mem_o           data access is waiting (combinational)
//   err_timeout_o         one-cycle pulse: transaction aborted by timeout
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic [DATA_W-1:0]   if_rdata_o,
    output logic                if_valid_o,
    input  logic                d_read_i,
    input  logic                d_write_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    input  logic [DATA_W/8-1:0] d_wstrb_i,
    output logic [DATA_W-1:0]   d_rdata_o,
    output logic                d_valid_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_wstrb_o,
    input  logic                mem_ack_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                stall_if_o,
    output logic                stall_mem_o,
    output logic                err_timeout_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                last_d_q, last_d_d;
    logic [7:0]          wait_cnt_q, wait_cnt_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                if_valid_q, if_valid_d;
    logic                d_valid_q, d_valid_d;
    logic                err_q, err_d;

    // A requester whose access completes this cycle still has its request
    // high (it only sees the valid pulse now), so it is masked out of the
    // arbitration for this one cycle.
    logic want_f, want_d, grant_d;
    assign want_f  = if_req_i & ~if_valid_q;
    assign want_d  = (d_read_i | d_write_i) & ~d_valid_q;
    // Data wins unless it won the previous grant and fetch is also waiting.
    assign grant_d = want_d & ~(want_f & last_d_q);

    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        wait_cnt_d  = wait_cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_valid_d  = 1'b0;
        d_valid_d   = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                // mem_ack_i is deliberately ignored here.
                if (want_f | want_d) begin
                    mem_req_d  = 1'b1;
                    wait_cnt_d = 8'd0;
                    last_d_d   = grant_d;
                    if (grant_d) begin
                        state_d     = DATA;
                        // read+write together is treated as a write
                        mem_we_d    = d_write_i;
                        mem_addr_d  = d_addr_i;
                        mem_wdata_d = d_wdata_i;
                        mem_wstrb_d = d_write_i ? d_wstrb_i : '0;
                    end else begin
                        state_d     = FETCH;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr_i;
                        mem_wdata_d = '0;
                        mem_wstrb_d = '0;
                    end
                end
            end
            FETCH, DATA: begin
                if (mem_ack_i) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                    if (state_q == FETCH) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mem_rdata_i;
                    end else begin
                        d_valid_d = 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_d = mem_rdata_i;
                        end
                    end
                end else if (wait_cnt_q == LAST_WAIT) begin
                    // Abort; the requester stays stalled and is re-arbitrated.
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b0;
            wait_cnt_q  <= 8'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_valid_q  <= if_valid_d;
            d_valid_q   <= d_valid_d;
            err_q       <= err_d;
        end
    end

    assign mem_req_o     = mem_req_q;
    assign mem_we_o      = mem_we_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_wdata_o   = mem_wdata_q;
    assign mem_wstrb_o   = mem_wstrb_q;
    assign if_rdata_o    = if_rdata_q;
    assign if_valid_o    = if_valid_q;
    assign d_rdata_o     = d_rdata_q;
    assign d_valid_o     = d_valid_q;
    assign err_timeout_o = err_q;
    assign stall_if_o    = if_req_i & ~if_valid_q;
    assign stall_mem_o   = (d_read_i | d_write_i) & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Purpose:
//   Self-checking bench for mem_port_arbiter: directed scenarios (reset,
//   fetch, load/store, contention, timeout, wait states, reset mid-access)
//   followed by randomized traffic compared against a transaction-level
//   reference model (grant stamps, alternation by last grant, timeout by
//   elapsed cycles).
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int MW = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          d_read, d_write;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [SW-1:0] d_wstrb;
    logic [DW-1:0] d_rdata;
    logic          d_valid;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [SW-1:0] mem_wstrb;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          stall_if, stall_mem, err_timeout;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    bit            m_busy, m_is_d, m_last_d, m_we;
    bit            m_if_valid, m_d_valid, m_err;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_if_rdata, m_d_rdata;
    logic [SW-1:0] m_wstrb;
    int            cyc, m_grant_cyc;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr),
        .if_rdata_o(if_rdata), .if_valid_o(if_valid),
        .d_read_i(d_read), .d_write_i(d_write), .d_addr_i(d_addr),
        .d_wdata_i(d_wdata), .d_wstrb_i(d_wstrb),
        .d_rdata_o(d_rdata), .d_valid_o(d_valid),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb),
        .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
        .stall_if_o(stall_if), .stall_mem_o(stall_mem),
        .err_timeout_o(err_timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; if_req = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_ack = 1'b0;
        tick(); tick();
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req: got %0h expected 0", mem_req); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_mem_we: got %0h expected 0", mem_we); end
        vectors++; if (mem_addr !== '0) begin miscompares++; $display("FAIL reset_mem_addr: got %0h expected 0", mem_addr); end
        vectors++; if (mem_wstrb !== '0) begin miscompares++; $display("FAIL reset_mem_wstrb: got %0h expected 0", mem_wstrb); end
        vectors++; if ({if_valid, d_valid, err_timeout} !== 3'b000) begin miscompares++; $display("FAIL reset_pulses: got %0b expected 000", {if_valid, d_valid, err_timeout}); end
        vectors++; if (if_rdata !== '0 || d_rdata !== '0) begin miscompares++; $display("FAIL reset_rdata: got %0h/%0h expected 0/0", if_rdata, d_rdata); end
        vectors++; if ({stall_if, stall_mem} !== 2'b00) begin miscompares++; $display("FAIL reset_stall: got %0b expected 00", {stall_if, stall_mem}); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fetch();
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0 || mem_wstrb !== '0) begin miscompares++; $display("FAIL fetch_cmd: got req=%0h addr=%0h we=%0h strb=%0h expected 1/100/0/0", mem_req, mem_addr, mem_we, mem_wstrb); end
        vectors++; if (stall_if !== 1'b1) begin miscompares++; $display("FAIL fetch_stall_wait: got %0h expected 1", stall_if); end
        mem_ack = 1'b1; mem_rdata = 32'h00500093;
        tick();
        vectors++; if (if_valid !== 1'b1 || if_rdata !== 32'h00500093) begin miscompares++; $display("FAIL fetch_done: got valid=%0h data=%0h expected 1/00500093", if_valid, if_rdata); end
        vectors++; if (mem_req !== 1'b0 || stall_if !== 1'b0) begin miscompares++; $display("FAIL fetch_release: got req=%0h stall=%0h expected 0/0", mem_req, stall_if); end
        mem_ack = 1'b0; if_req = 1'b0;
        tick();
        vectors++; if (if_valid !== 1'b0 || if_rdata !== 32'h00500093 || stall_if !== 1'b0) begin miscompares++; $display("FAIL fetch_after: got valid=%0h data=%0h stall=%0h expected 0/00500093/0", if_valid, if_rdata, stall_if); end
    endtask

    task automatic test_load_store();
        d_read = 1'b1; d_addr = 32'h20;
        tick();
        vectors++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h20 || mem_wstrb !== '0) begin miscompares++; $display("FAIL load_cmd: got req=%0h we=%0h addr=%0h strb=%0h expected 1/0/20/0", mem_req, mem_we, mem_addr, mem_wstrb); end
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        vectors++; if (d_valid !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL load_done: got valid=%0h data=%0h expected 1/deadbeef", d_valid, d_rdata); end
        // store offered during the valid cycle must wait one cycle
        mem_ack = 1'b0; d_read = 1'b0; d_write = 1'b1;
        d_addr = 32'h24; d_wdata = 32'h12345678; d_wstrb = 4'b0011;
        tick();
        vectors++; if (mem_req !== 1'b0 || d_valid !== 1'b0) begin miscompares++; $display("FAIL store_gap: got req=%0h valid=%0h expected 0/0", mem_req, d_valid); end
        tick();
        vectors++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h24 || mem_wdata !== 32'h12345678 || mem_wstrb !== 4'b0011) begin miscompares++; $display("FAIL store_cmd: got req=%0h we=%0h addr=%0h wdata=%0h strb=%0h expected 1/1/24/12345678/3", mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb); end
        mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        tick();
        vectors++; if (d_valid !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL store_done: got valid=%0h data=%0h expected 1/deadbeef", d_valid, d_rdata); end
        // read and write together behave as a write
        mem_ack = 1'b0; d_read = 1'b1; d_addr = 32'h28; d_wdata = 32'hA5A5A5A5; d_wstrb = 4'b1000;
        tick(); tick();
        vectors++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wstrb !== 4'b1000) begin miscompares++; $display("FAIL rw_is_write: got req=%0h we=%0h strb=%0h expected 1/1/8", mem_req, mem_we, mem_wstrb); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0; d_read = 1'b0; d_write = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        logic [DW-1:0] rd;
        bit exp_d;
        int waitc;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        if_req = 1'b1; if_addr = 32'h200; d_read = 1'b1; d_addr = 32'h40;
        for (int g = 0; g < 6; g++) begin
            waitc = 0;
            while (mem_req !== 1'b1 && waitc < 10) begin tick(); waitc++; end
            exp_d = (g % 2 == 0);
            vectors++; if (mem_addr !== (exp_d ? 32'h40 : 32'h200) || mem_req !== 1'b1) begin miscompares++; $display("FAIL contention_grant%0d: got req=%0h addr=%0h expected 1/%0h", g, mem_req, mem_addr, exp_d ? 32'h40 : 32'h200); end
            rd = $urandom; mem_ack = 1'b1; mem_rdata = rd;
            tick();
            mem_ack = 1'b0;
            if (exp_d) begin
                vectors++; if (d_valid !== 1'b1 || if_valid !== 1'b0 || d_rdata !== rd) begin miscompares++; $display("FAIL contention_done%0d: got dv=%0h iv=%0h data=%0h expected 1/0/%0h", g, d_valid, if_valid, d_rdata, rd); end
            end else begin
                vectors++; if (if_valid !== 1'b1 || d_valid !== 1'b0 || if_rdata !== rd) begin miscompares++; $display("FAIL contention_done%0d: got iv=%0h dv=%0h data=%0h expected 1/0/%0h", g, if_valid, d_valid, if_rdata, rd); end
            end
        end
        if_req = 1'b0; d_read = 1'b0;
        tick(); tick();
    endtask

    task automatic test_timeout();
        int cnt = 1;
        bit bad_pulse = 0;
        d_write = 1'b1; d_addr = 32'h80; d_wdata = 32'hCAFEF00D; d_wstrb = 4'hF; mem_ack = 1'b0;
        tick();
        while (cnt < 40) begin
            tick();
            if (d_valid !== 1'b0 || (mem_req === 1'b1 && err_timeout !== 1'b0)) bad_pulse = 1;
            if (mem_req === 1'b1) cnt++; else break;
        end
        vectors++; if (cnt != MW) begin miscompares++; $display("FAIL timeout_len: got %0d cycles expected %0d", cnt, MW); end
        vectors++; if (bad_pulse) begin miscompares++; $display("FAIL timeout_spurious: got stray pulse expected none"); end
        vectors++; if (err_timeout !== 1'b1 || d_valid !== 1'b0 || stall_mem !== 1'b1) begin miscompares++; $display("FAIL timeout_pulse: got err=%0h valid=%0h stall=%0h expected 1/0/1", err_timeout, d_valid, stall_mem); end
        tick();
        vectors++; if (mem_req !== 1'b1 || err_timeout !== 1'b0 || mem_addr !== 32'h80) begin miscompares++; $display("FAIL timeout_reissue: got req=%0h err=%0h addr=%0h expected 1/0/80", mem_req, err_timeout, mem_addr); end
        mem_ack = 1'b1;
        tick();
        vectors++; if (d_valid !== 1'b1) begin miscompares++; $display("FAIL timeout_recover: got %0h expected 1", d_valid); end
        mem_ack = 1'b0; d_write = 1'b0;
        tick();
    endtask

    task automatic test_wait_states();
        logic [DW-1:0] wd;
        bit unstable = 0;
        wd = $urandom;
        d_write = 1'b1; d_addr = 32'h30; d_wdata = wd; d_wstrb = 4'b0110; mem_ack = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            d_addr = $urandom; d_wdata = $urandom; d_wstrb = 4'(i);
            tick();
            if (mem_req !== 1'b1 || mem_addr !== 32'h30 || mem_wdata !== wd || mem_wstrb !== 4'b0110 || mem_we !== 1'b1 || d_valid !== 1'b0) unstable = 1;
        end
        vectors++; if (unstable) begin miscompares++; $display("FAIL wait_stable: got changing fields, last addr=%0h wdata=%0h expected 30/%0h", mem_addr, mem_wdata, wd); end
        mem_ack = 1'b1;
        tick();
        vectors++; if (d_valid !== 1'b1 || mem_req !== 1'b0) begin miscompares++; $display("FAIL wait_valid: got valid=%0h req=%0h expected 1/0", d_valid, mem_req); end
        mem_ack = 1'b0; d_write = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        bit stray = 0;
        d_read = 1'b1; d_addr = 32'h44; mem_ack = 1'b0;
        tick(); tick();
        vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL rstmid_busy: got %0h expected 1", mem_req); end
        rst_n = 1'b0;
        tick();
        vectors++; if (mem_req !== 1'b0 || mem_addr !== '0 || d_valid !== 1'b0 || err_timeout !== 1'b0 || d_rdata !== '0 || if_rdata !== '0) begin miscompares++; $display("FAIL rstmid_clear: got req=%0h addr=%0h dv=%0h err=%0h expected all 0", mem_req, mem_addr, d_valid, err_timeout); end
        rst_n = 1'b1; d_read = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1234;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (mem_req !== 1'b0 || d_valid !== 1'b0 || if_valid !== 1'b0 || err_timeout !== 1'b0) stray = 1;
        end
        vectors++; if (stray) begin miscompares++; $display("FAIL rstmid_release: got stray activity expected none"); end
        mem_ack = 1'b0;
    endtask

    // Transaction-level reference: one outstanding access at a time, granted
    // to whoever waits (excluding a requester in its completion cycle),
    // alternating after the last grant; aborted MW cycles after the grant.
    task automatic model_edge();
        bit old_if_v = m_if_valid;
        bit old_d_v  = m_d_valid;
        bit want_f, want_d;
        cyc++;
        m_if_valid = 0; m_d_valid = 0; m_err = 0;
        if (m_busy) begin
            if (mem_ack) begin
                m_busy = 0;
                if (m_is_d) begin m_d_valid = 1; if (!m_we) m_d_rdata = mem_rdata; end
                else begin m_if_valid = 1; m_if_rdata = mem_rdata; end
            end else if (cyc - m_grant_cyc == MW) begin
                m_busy = 0; m_err = 1;
            end
        end else begin
            want_f = if_req && !old_if_v;
            want_d = (d_read || d_write) && !old_d_v;
            if (want_f || want_d) begin
                m_is_d = want_d && !(want_f && m_last_d);
                m_last_d = m_is_d; m_busy = 1; m_grant_cyc = cyc;
                if (m_is_d) begin
                    m_we = d_write; m_addr = d_addr; m_wdata = d_wdata;
                    m_wstrb = d_write ? d_wstrb : '0;
                end else begin
                    m_we = 0; m_addr = if_addr; m_wstrb = '0;
                end
            end
        end
    endtask

    task automatic test_random();
        int unsigned delay = 0, age = 0, k;
        rst_n = 1'b0; if_req = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_ack = 1'b0;
        tick();
        rst_n = 1'b1;
        m_busy = 0; m_last_d = 0; m_if_valid = 0; m_d_valid = 0; m_err = 0;
        m_if_rdata = '0; m_d_rdata = '0; cyc = 0; m_grant_cyc = 0;
        for (int n = 0; n < 700; n++) begin
            // fetch requester
            if (if_req && m_if_valid) begin
                if ($urandom_range(1) == 0) if_req = 1'b0; else if_addr = $urandom;
            end else if (!if_req) begin
                if ($urandom_range(2) == 0) begin if_req = 1'b1; if_addr = $urandom; end
            end else if ($urandom_range(4) == 0) begin
                if_addr = $urandom;
            end
            // data requester
            if ((d_read || d_write) && (m_d_valid || !(d_read || d_write))) begin
                if ($urandom_range(1) == 0) begin d_read = 1'b0; d_write = 1'b0; end
                else begin
                    k = $urandom_range(2); d_read = (k != 1); d_write = (k != 0);
                    d_addr = $urandom; d_wdata = $urandom; d_wstrb = 4'($urandom_range(15));
                end
            end else if (!(d_read || d_write)) begin
                if ($urandom_range(2) == 0) begin
                    k = $urandom_range(2); d_read = (k != 1); d_write = (k != 0);
                    d_addr = $urandom; d_wdata = $urandom; d_wstrb = 4'($urandom_range(15));
                end
            end else if ($urandom_range(4) == 0) begin
                d_addr = $urandom; d_wdata = $urandom;
            end
            // memory responder
            if (mem_req === 1'b1) begin
                if (age == 0) delay = ($urandom_range(9) == 0) ? 20 : $urandom_range(4);
                mem_ack = (age >= delay); age++;
            end else begin
                age = 0; mem_ack = 1'b0;
            end
            mem_rdata = $urandom;
            model_edge();
            tick();
            vectors++; if (mem_req !== m_busy) begin miscompares++; $display("FAIL rnd_req@%0d: got %0h expected %0h", cyc, mem_req, m_busy); end
            if (m_busy) begin
                vectors++; if (mem_addr !== m_addr || mem_we !== m_we || mem_wstrb !== m_wstrb) begin miscompares++; $display("FAIL rnd_cmd@%0d: got addr=%0h we=%0h strb=%0h expected %0h/%0h/%0h", cyc, mem_addr, mem_we, mem_wstrb, m_addr, m_we, m_wstrb); end
                if (m_we) begin
                    vectors++; if (mem_wdata !== m_wdata) begin miscompares++; $display("FAIL rnd_wdata@%0d: got %0h expected %0h", cyc, mem_wdata, m_wdata); end
                end
            end
            vectors++; if ({if_valid, d_valid, err_timeout} !== {m_if_valid, m_d_valid, m_err}) begin miscompares++; $display("FAIL rnd_pulses@%0d: got %0b expected %0b", cyc, {if_valid, d_valid, err_timeout}, {m_if_valid, m_d_valid, m_err}); end
            vectors++; if (if_rdata !== m_if_rdata || d_rdata !== m_d_rdata) begin miscompares++; $display("FAIL rnd_rdata@%0d: got %0h/%0h expected %0h/%0h", cyc, if_rdata, d_rdata, m_if_rdata, m_d_rdata); end
            vectors++; if (stall_if !== (if_req && !m_if_valid) || stall_mem !== ((d_read || d_write) && !m_d_valid)) begin miscompares++; $display("FAIL rnd_stall@%0d: got %0b%0b expected %0b%0b", cyc, stall_if, stall_mem, (if_req && !m_if_valid), ((d_read || d_write) && !m_d_valid)); end
        end
        if_req = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_ack = 1'b0;
    endtask

    initial begin
        if_addr = '0; d_addr = '0; d_wdata = '0; d_wstrb = '0; mem_rdata = '0;
        test_reset();
        test_fetch();
        test_load_store();
        test_contention();
        test_timeout();
        test_wait_states();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected $finish");
        $fatal(1, "watchdog expired");
    end

endmodule
